record_serializer: RTL and testbench
====================================

# record_serializer

Consumes one fixed-layout unpacked-style record per handshake and emits its fields one word per beat on a valid/ready stream. It sits directly downstream of the blocks that build records with structure assignment patterns, such as `'{A:1, BC1:'{B:2,C:3}, BC2:'{B:4,C:5}}` or `'{default:10}`. It is the stage that flattens those records onto a word-wide bus. Field 0 (`A`) goes out first, and records may stream back-to-back with no idle cycles.

## Interface
- `WIDTH`, 32, bits per field and per output word (matches `int`).
- `NFIELDS`, 5, fields per record (`A`, `BC1.B`, `BC1.C`, `BC2.B`, `BC2.C`); must be ≥ 2.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: `in_rec` holds a record.
- `in_ready` output 1: block can accept a record this cycle.
- `in_rec` input `NFIELDS*WIDTH`: packed record; field i at bits `[i*WIDTH +: WIDTH]`, field 0 (`A`) at LSBs.
- `in_default` input 1: when set with the record, every field is replaced by `in_fill` (models `'{default:x}`).
- `in_fill` input `WIDTH`: fill value used when `in_default`=1.
- `out_valid` output 1: `out_data` holds a field.
- `out_ready` input 1: downstream accepts the current word.
- `out_data` output `WIDTH`: current field value.
- `out_idx` output `$clog2(NFIELDS)`: index of the current field.
- `out_last` output 1: current word is field `NFIELDS-1`.
- `rec_count` output 16: number of records fully emitted; wraps modulo 2^16.

## Operation
- Two states.
  - IDLE: no record held.
  - SEND: record held in an internal `NFIELDS*WIDTH` register, emitting field `out_idx`.
- `in_ready` is combinational: 1 in IDLE, or in SEND when `out_valid && out_ready && out_last`. It is 0 otherwise.
- Accept = `in_valid && in_ready`. On accept:
  - Load the record register with `in_rec`, or with `in_fill` replicated `NFIELDS` times if `in_default`.
  - Set `out_idx`=0 and go to SEND.
- Beat = `out_valid && out_ready`. On a beat with `out_idx` < `NFIELDS-1`, increment `out_idx`.
- On a beat with `out_last`:
  - Increment `rec_count`.
  - If accept occurs in the same cycle, reload and stay in SEND with `out_idx`=0.
  - Otherwise go to IDLE.
- In SEND, `out_valid`=1. `out_data` = field `out_idx` of the held record. `out_last` = (`out_idx`==`NFIELDS-1`).
- In IDLE, `out_valid`=0, `out_last`=0, `out_data`=0, `out_idx`=0.
- `in_rec`, `in_default` and `in_fill` are sampled only on accept; later changes are ignored.
- `out_data`, `out_idx` and `out_last` are stable while `out_valid && !out_ready`.

## Timing
- Reset values (asserted asynchronously, no clock needed): state IDLE, `out_valid`=0, `out_data`=0, `out_idx`=0, `out_last`=0, `rec_count`=0, record register 0. `in_ready`=1 as soon as `rst` deasserts.
- Latency: accept at edge N gives field 0 on `out_data` with `out_valid`=1 in cycle N+1.
- Throughput with `out_ready` held at 1:
  - One word per cycle.
  - A record occupies exactly `NFIELDS` cycles.
  - Back-to-back records have no bubble, because the last beat and the next accept share a cycle.
- Backpressure: `out_ready`=0 holds `out_idx` and `out_data`. `in_ready` stays 0 in SEND until the last beat.
- `rec_count` updates at the edge closing the last beat and is visible the following cycle. 16'hFFFF increments to 16'h0000.
- Reset mid-record discards the held record without counting it. The first cycle after reset shows IDLE outputs.
- `in_valid` with `in_ready`=0 is not an accept; the upstream holds the record.

## Test plan
- Record {A=1, B=2, C=3, B=4, C=5}, `out_ready`=1:
  - words 1, 2, 3, 4, 5 on 5 consecutive cycles, starting the cycle after accept;
  - `out_idx` 0..4;
  - `out_last` only on 5;
  - `rec_count`=1.
- `in_default`=1, `in_fill`=10, `in_rec`=all ones: five words of 10, `out_last` on the 5th.
- Two records {1,2,3,4,5} then {6,7,8,9,10} presented back-to-back with `out_ready`=1:
  - 10 consecutive valid beats, no gap;
  - second accept coincides with the beat of word 5;
  - `rec_count`=2.
- `out_ready`=0 for 3 cycles while `out_idx`=2:
  - `out_data`=3 held;
  - `in_ready`=0 throughout;
  - changing `in_rec` meanwhile does not alter the output sequence.
- `rst` pulsed mid-record at `out_idx`=3 (asynchronously, between edges):
  - `out_valid` drops immediately;
  - `rec_count` stays 0;
  - next record emits from field 0.
- `rec_count` driven to 16'hFFFF by 65535 records (or a forced preset), then one more record: `rec_count` becomes 16'h0000.

Source files
------------

// File: rtl/record_serializer.sv
// record_serializer: flattens one NFIELDS-word record per handshake onto a
// WIDTH-bit valid/ready stream, field 0 first, with no bubble between records.
module record_serializer #(
    parameter int WIDTH   = 32,
    parameter int NFIELDS = 5,
    localparam int IW     = (NFIELDS > 1) ? $clog2(NFIELDS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NFIELDS*WIDTH-1:0] in_rec,
    input  logic                     in_default,
    input  logic [WIDTH-1:0]         in_fill,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [IW-1:0]            out_idx,
    output logic                     out_last,
    output logic [15:0]              rec_count
);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    localparam logic [IW-1:0] LAST_IDX = IW'(NFIELDS - 1);

    state_t                     state;
    state_t                     state_next;
    logic [NFIELDS*WIDTH-1:0]   rec_q;
    logic [IW-1:0]              idx_q;
    logic [15:0]                count_q;

    logic                       sending;
    logic                       at_last;
    logic                       beat;
    logic                       accept;

    // Handshake terms shared by all three processes
    always_comb begin
        sending  = (state == SEND);
        at_last  = sending && (idx_q == LAST_IDX);
        beat     = sending && out_ready;
        in_ready = !sending || (beat && at_last);
        accept   = in_valid && in_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                if (beat && at_last && !accept) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A reload on the final beat takes priority over the index advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rec_q   <= '0;
            idx_q   <= '0;
            count_q <= '0;
        end else begin
            if (accept) begin
                rec_q <= in_default ? {NFIELDS{in_fill}} : in_rec;
                idx_q <= '0;
            end else if (beat && !at_last) begin
                idx_q <= idx_q + 1'b1;
            end
            if (beat && at_last) begin
                count_q <= count_q + 16'd1;
            end
        end
    end

    always_comb begin
        out_valid = sending;
        out_last  = at_last;
        out_idx   = '0;
        out_data  = '0;
        if (sending) begin
            out_idx  = idx_q;
            out_data = rec_q[int'(idx_q) * WIDTH +: WIDTH];
        end
    end

    assign rec_count = count_q;

endmodule

// File: tb/tb_record_serializer.sv
// tb_record_serializer: scoreboard bench for record_serializer; expected words
// are queued at each accept and popped on every observed output beat.
module tb_record_serializer;

    localparam int W  = 32;
    localparam int N  = 5;
    localparam int IW = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid;
    logic           in_ready;
    logic [N*W-1:0] in_rec;
    logic           in_default;
    logic [W-1:0]   in_fill;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [IW-1:0]  out_idx;
    logic           out_last;
    logic [15:0]    rec_count;

    record_serializer #(.WIDTH(W), .NFIELDS(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rec     (in_rec),
        .in_default (in_default),
        .in_fill    (in_fill),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .rec_count  (rec_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [W-1:0]  data;
        logic [IW-1:0] idx;
        logic          last;
    } beat_t;

    beat_t exp_q[$];
    beat_t exp_b;
    int    beat_log[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Values sampled mid low-phase are the ones the next rising edge sees
    always @(negedge clk) begin
        #2;
        if (!rst && out_valid && out_ready) begin
            beat_log.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 64'd1, 64'd0);
            end else begin
                exp_b = exp_q.pop_front();
                check("out_data", 64'(out_data), 64'(exp_b.data));
                check("out_idx", 64'(out_idx), 64'(exp_b.idx));
                check("out_last", 64'(out_last), 64'(exp_b.last));
            end
        end
    end

    function automatic logic [N*W-1:0] mk(input int a, input int b, input int c,
                                          input int d, input int e);
        return {e[W-1:0], d[W-1:0], c[W-1:0], b[W-1:0], a[W-1:0]};
    endfunction

    task automatic send(input logic [N*W-1:0] rec, input logic dflt,
                        input logic [W-1:0] fill, output int acc);
        int k = 0;
        @(negedge clk);
        in_valid   = 1'b1;
        in_rec     = rec;
        in_default = dflt;
        in_fill    = fill;
        #1;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (!in_ready) begin
            check("accept_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc;
        for (int i = 0; i < N; i++) begin
            exp_b.data = dflt ? fill : rec[i*W +: W];
            exp_b.idx  = IW'(i);
            exp_b.last = (i == N - 1);
            exp_q.push_back(exp_b);
        end
        @(posedge clk);
    endtask

    task automatic idle_in();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while ((exp_q.size() != 0 || out_valid) && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("drain_timeout", 64'(k < 100), 64'd1);
        @(negedge clk);
    endtask

    task automatic wait_idx(input int idx);
        int k = 0;
        while (!(out_valid && out_idx == IW'(idx)) && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("wait_idx_timeout", 64'(k < 20), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1;
        in_valid   = 1'b0;
        in_rec     = '0;
        in_default = 1'b0;
        in_fill    = '0;
        out_ready  = 1'b1;

        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_idx", 64'(out_idx), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_rec_count", 64'(rec_count), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Asynchronous reset in the middle of a record
        send(mk(11, 12, 13, 14, 15), 1'b0, '0, a0);
        idle_in();
        wait_idx(3);
        #1;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_out_idx", 64'(out_idx), 64'd0);
        check("arst_rec_count", 64'(rec_count), 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_valid", 64'(out_valid), 64'd0);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        check("post_rst_count", 64'(rec_count), 64'd0);

        // Single record, latency and one word per cycle
        beat_log.delete();
        send(mk(1, 2, 3, 4, 5), 1'b0, '0, a0);
        idle_in();
        drain();
        check("t1_rec_count", 64'(rec_count), 64'd1);
        check("t1_beats", 64'(beat_log.size()), 64'd5);
        if (beat_log.size() == 5) begin
            check("t1_latency", 64'(beat_log[0]), 64'(a0 + 1));
            check("t1_span", 64'(beat_log[4] - beat_log[0]), 64'd4);
        end

        // Default fill overrides in_rec
        send('1, 1'b1, 32'd10, a0);
        idle_in();
        drain();
        check("t2_rec_count", 64'(rec_count), 64'd2);

        // Back-to-back records with no bubble
        beat_log.delete();
        send(mk(1, 2, 3, 4, 5), 1'b0, '0, a0);
        send(mk(6, 7, 8, 9, 10), 1'b0, '0, a1);
        idle_in();
        drain();
        check("t3_beats", 64'(beat_log.size()), 64'd10);
        if (beat_log.size() == 10) begin
            check("t3_span", 64'(beat_log[9] - beat_log[0]), 64'd9);
            check("t3_overlap", 64'(a1), 64'(beat_log[4]));
        end
        check("t3_rec_count", 64'(rec_count), 64'd4);

        // Backpressure at field 2 while upstream data changes
        send(mk(1, 2, 3, 4, 5), 1'b0, '0, a0);
        idle_in();
        wait_idx(2);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_rec     = {5{$urandom()}};
            in_fill    = $urandom();
            in_default = 1'(i);
            #3;
            check("t4_hold_data", 64'(out_data), 64'd3);
            check("t4_hold_idx", 64'(out_idx), 64'd2);
            check("t4_hold_valid", 64'(out_valid), 64'd1);
            check("t4_in_ready", 64'(in_ready), 64'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        drain();
        check("t4_rec_count", 64'(rec_count), 64'd5);

        // Counter wrap from a preset of 16'hFFFF
        force dut.count_q = 16'hFFFF;
        @(negedge clk);
        release dut.count_q;
        #1;
        check("t5_preset", 64'(rec_count), 64'hFFFF);
        send(mk(21, 22, 23, 24, 25), 1'b0, '0, a0);
        idle_in();
        drain();
        check("t5_wrap", 64'(rec_count), 64'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
